// File: rtl/ps_stream_arbiter.sv
// Packet-boundary arbiter sharing the PS setpoint link between the FOFB and AWG streams.
// Registered output mux; switches only between packets, with a stall timeout for hung sources.
module ps_stream_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter     DEBUG          = "false"
) (
    input  logic                  sysClk,
    input  logic                  sysReset,
    input  logic                  AWGrequest,
    output logic                  AWGenabled,
    input  logic                  statusClear,
    input  logic [DATA_WIDTH-1:0] fofbTDATA,
    input  logic                  fofbTVALID,
    input  logic                  fofbTLAST,
    input  logic [DATA_WIDTH-1:0] awgTDATA,
    input  logic                  awgTVALID,
    input  logic                  awgTLAST,
    output logic [DATA_WIDTH-1:0] psTDATA,
    output logic                  psTVALID,
    output logic                  psTLAST,
    output logic [31:0]           status
);

    typedef enum logic [1:0] {
        ST_FOFB    = 2'd0,
        ST_TO_AWG  = 2'd1,
        ST_AWG     = 2'd2,
        ST_TO_FOFB = 2'd3
    } state_t;

    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    (* mark_debug = DEBUG *) state_t state;
    state_t                  state_next;

    logic                  inpkt_fofb;
    logic                  inpkt_awg;
    logic [STALL_W-1:0]    stall_cnt;
    logic [7:0]            drop_cnt;
    logic [15:0]           pkt_cnt;
    logic                  timeout_flag;

    (* mark_debug = DEBUG *) logic [DATA_WIDTH-1:0] data_p1;
    (* mark_debug = DEBUG *) logic                  vld_p1;
    (* mark_debug = DEBUG *) logic                  last_p1;

    logic                  sel_awg;
    logic                  in_switch;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  inpkt_sel;
    logic                  oth_valid;
    logic                  inpkt_oth;
    logic                  boundary_sel;
    logic                  idle_oth;
    logic                  stall;
    logic                  stall_expired;
    logic                  timeout;

    // Bit 1 of the state encoding is the current owner, bit 0 marks a pending hand-over.
    assign sel_awg   = state[1];
    assign in_switch = state[0];

    assign sel_valid = sel_awg ? awgTVALID : fofbTVALID;
    assign sel_last  = sel_awg ? awgTLAST  : fofbTLAST;
    assign sel_data  = sel_awg ? awgTDATA  : fofbTDATA;
    assign inpkt_sel = sel_awg ? inpkt_awg : inpkt_fofb;
    assign oth_valid = sel_awg ? fofbTVALID : awgTVALID;
    assign inpkt_oth = sel_awg ? inpkt_fofb : inpkt_awg;

    assign boundary_sel  = (!inpkt_sel && !sel_valid) || (sel_valid && sel_last);
    assign idle_oth      = !inpkt_oth && !oth_valid;
    assign stall         = in_switch && inpkt_sel && !sel_valid;
    assign stall_expired = stall && (stall_cnt == STALL_LAST);

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            ST_FOFB: begin
                if (AWGrequest) state_next = ST_TO_AWG;
            end
            ST_TO_AWG: begin
                if (!AWGrequest) begin
                    state_next = ST_FOFB;
                end else if (idle_oth && (boundary_sel || stall_expired)) begin
                    state_next = ST_AWG;
                    timeout    = stall_expired;
                end
            end
            ST_AWG: begin
                if (!AWGrequest) state_next = ST_TO_FOFB;
            end
            ST_TO_FOFB: begin
                if (AWGrequest) begin
                    state_next = ST_AWG;
                end else if (idle_oth && (boundary_sel || stall_expired)) begin
                    state_next = ST_FOFB;
                    timeout    = stall_expired;
                end
            end
            default: state_next = ST_FOFB;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state        <= ST_FOFB;
            AWGenabled   <= 1'b0;
            inpkt_fofb   <= 1'b0;
            inpkt_awg    <= 1'b0;
            stall_cnt    <= '0;
            drop_cnt     <= 8'd0;
            pkt_cnt      <= 16'd0;
            timeout_flag <= 1'b0;
        end else begin
            state      <= state_next;
            AWGenabled <= state_next[1];

            // A forced hand-over abandons the stalled packet of the old owner.
            if (timeout && !sel_awg)  inpkt_fofb <= 1'b0;
            else if (fofbTVALID)      inpkt_fofb <= !fofbTLAST;
            if (timeout && sel_awg)   inpkt_awg  <= 1'b0;
            else if (awgTVALID)       inpkt_awg  <= !awgTLAST;

            if ((state_next != state) || sel_valid) stall_cnt <= '0;
            else if (stall && (stall_cnt != STALL_LAST)) stall_cnt <= stall_cnt + 1'b1;

            if (statusClear)    drop_cnt <= 8'd0;
            else if (oth_valid) drop_cnt <= sat_inc8(drop_cnt);

            if (statusClear)  timeout_flag <= 1'b0;
            else if (timeout) timeout_flag <= 1'b1;

            if (sel_valid && sel_last) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

    // Output stage p1: one-cycle registered mux from the currently selected source.
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= sel_valid;
            last_p1 <= sel_valid && sel_last;
            if (sel_valid) data_p1 <= sel_data;
        end
    end

    assign psTDATA  = data_p1;
    assign psTVALID = vld_p1;
    assign psTLAST  = last_p1;

    assign status = {AWGrequest, AWGenabled, state, timeout_flag, 3'b000, drop_cnt, pkt_cnt};

endmodule
